// File: rtl/symbol_entry_encoder.sv
// Two-button symbol entry front end: synchronizes and debounces the buttons,
// then emits one-cycle symbol strobes (x0 valid, x1 value) and conflict pulses.
module symbol_entry_encoder #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             btn_zero,
   input  logic             btn_one,
   output logic             x1,
   output logic             x0,
   output logic             conflict,
   output logic [CNT_W-1:0] sym_count
);

   // state    | meaning
   // ARMED    | both debounced levels low, next single rise emits a symbol
   // WAIT_REL | event emitted, rises ignored until both buttons debounce released
   typedef enum logic {
      ARMED    = 1'b0,
      WAIT_REL = 1'b1
   } state_t;

   localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   state_t                   state;
   logic [1:0]               raw;
   logic [1:0]               s1;
   logic [1:0]               s2;
   logic [1:0]               deb;
   logic [1:0]               deb_d;
   logic [1:0]               rise;
   logic [1:0][DB_W-1:0]     db_cnt;

   // bit 0 tracks btn_zero, bit 1 tracks btn_one
   assign raw  = {btn_one, btn_zero};
   assign rise = deb & ~deb_d;

   always_ff @(posedge clk) begin
      if (!reset) begin
         s1     <= '0;
         s2     <= '0;
         deb    <= '0;
         deb_d  <= '0;
         db_cnt <= '0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         deb_d <= deb;
         for (int i = 0; i < 2; i++) begin
            if (s2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= s2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= ARMED;
         x0        <= 1'b0;
         x1        <= 1'b0;
         conflict  <= 1'b0;
         sym_count <= '0;
      end else begin
         x0       <= 1'b0;
         x1       <= 1'b0;
         conflict <= 1'b0;
         case (state)
            ARMED: begin
               if (rise == 2'b11) begin
                  conflict <= 1'b1;
                  state    <= WAIT_REL;
               end else if (rise != 2'b00) begin
                  x0        <= 1'b1;
                  x1        <= rise[1];
                  sym_count <= sym_count + 1'b1;
                  state     <= WAIT_REL;
               end
            end
            WAIT_REL: begin
               if (deb == 2'b00) state <= ARMED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_symbol_entry_encoder.sv
// Scoreboard bench for symbol_entry_encoder: a cycle model of the button rules
// queues expected events, a monitor compares them against the DUT outputs.
module tb_symbol_entry_encoder;

   localparam int DEB   = 4;
   localparam int CNT_W = 8;

   logic             clk;
   logic             reset;
   logic             btn_zero;
   logic             btn_one;
   logic             x1;
   logic             x0;
   logic             conflict;
   logic [CNT_W-1:0] sym_count;

   symbol_entry_encoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .btn_zero  (btn_zero),
      .btn_one   (btn_one),
      .x1        (x1),
      .x0        (x0),
      .conflict  (conflict),
      .sym_count (sym_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int cyc;
      bit conf;
      bit val;
   } exp_t;

   exp_t             sb[$];
   int               checks = 0;
   int               errors = 0;
   int               edge_no = 0;
   bit               mon_en = 0;

   // reference model state
   bit [1:0]         m_s1, m_s2, m_deb, m_rose;
   int               streak[2];
   bit               armed;
   logic [CNT_W-1:0] m_count;

   task automatic model_step();
      bit [1:0] raw;
      bit [1:0] new_rose;
      exp_t     e;
      raw = {btn_one, btn_zero};
      edge_no++;
      if (!reset) begin
         m_s1 = 0; m_s2 = 0; m_deb = 0; m_rose = 0;
         streak[0] = 0; streak[1] = 0;
         armed = 1; m_count = 0;
         return;
      end
      if (armed) begin
         if (m_rose == 2'b11) begin
            e.cyc = edge_no; e.conf = 1; e.val = 0;
            sb.push_back(e);
            armed = 0;
         end else if (m_rose != 2'b00) begin
            e.cyc = edge_no; e.conf = 0; e.val = m_rose[1];
            sb.push_back(e);
            m_count = m_count + 1'b1;
            armed = 0;
         end
      end else if (m_deb == 2'b00) begin
         armed = 1;
      end
      // a level flips once DEB consecutive synchronized samples disagree with it
      new_rose = 0;
      for (int b = 0; b < 2; b++) begin
         if (m_s2[b] != m_deb[b]) begin
            streak[b]++;
            if (streak[b] == DEB) begin
               m_deb[b]   = m_s2[b];
               streak[b]  = 0;
               new_rose[b] = m_deb[b];
            end
         end else begin
            streak[b] = 0;
         end
      end
      m_rose = new_rose;
      m_s2   = m_s1;
      m_s1   = raw;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            checks++;
            if (sb.size() > 0 && sb[0].cyc == edge_no) begin
               e = sb.pop_front();
               if (x0 !== !e.conf || x1 !== (e.conf ? 1'b0 : e.val) || conflict !== e.conf) begin
                  errors++;
                  $display("FAIL event edge=%0d got x0=%b x1=%b conflict=%b want x0=%b x1=%b conflict=%b",
                           edge_no, x0, x1, conflict, !e.conf, e.conf ? 1'b0 : e.val, e.conf);
               end
            end else if (x0 !== 1'b0 || x1 !== 1'b0 || conflict !== 1'b0) begin
               errors++;
               $display("FAIL idle edge=%0d got x0=%b x1=%b conflict=%b want all 0",
                        edge_no, x0, x1, conflict);
            end
            checks++;
            if (sym_count !== m_count) begin
               errors++;
               $display("FAIL sym_count edge=%0d got %0d want %0d", edge_no, sym_count, m_count);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", name, act, exp);
      end
   endtask

   task automatic press(input bit which, input int hold, input int rel);
      if (which) btn_one = 1; else btn_zero = 1;
      cyc(hold);
      btn_one = 0; btn_zero = 0;
      cyc(rel);
   endtask

   initial begin
      reset = 0; btn_zero = 0; btn_one = 0;
      cyc(3);
      mon_en = 1;
      chk("reset sym_count", int'(sym_count), 0);
      chk("reset x0", int'(x0), 0);
      reset = 1;
      cyc(2);

      // btn_one held: single strobe, nothing more while held
      btn_one = 1;
      cyc(20);
      chk("hold one count", int'(sym_count), 1);
      btn_one = 0;
      cyc(12);

      // single-sample bounce never debounces
      for (int i = 0; i < 6; i++) begin
         btn_zero = (i % 2 == 0);
         cyc(1);
      end
      btn_zero = 0;
      cyc(10);
      chk("bounce count", int'(sym_count), 1);
      press(0, 10, 12);
      chk("zero press count", int'(sym_count), 2);

      // simultaneous press gives conflict, count held
      btn_zero = 1; btn_one = 1;
      cyc(15);
      chk("conflict count", int'(sym_count), 2);
      btn_zero = 0; btn_one = 0;
      cyc(12);
      press(0, 10, 12);
      chk("after conflict count", int'(sym_count), 3);

      // second button while first held is ignored
      btn_zero = 1;
      cyc(10);
      btn_one = 1;
      cyc(10);
      btn_zero = 0; btn_one = 0;
      cyc(12);
      chk("overlap count", int'(sym_count), 4);
      press(1, 10, 12);
      chk("overlap then one count", int'(sym_count), 5);

      // 256 strobes wrap the counter back to where it started
      for (int i = 0; i < 256; i++) press(i[0], 8, 8);
      chk("wrap count", int'(sym_count), 5);

      // reset just before a strobe discards it; still-held button re-strobes
      btn_one = 1;
      cyc(5);
      reset = 0;
      cyc(2);
      chk("mid reset count", int'(sym_count), 0);
      reset = 1;
      cyc(20);
      chk("post reset count", int'(sym_count), 1);
      btn_one = 0;
      cyc(12);

      // random bouncing and overlapping presses
      for (int i = 0; i < 60; i++) begin
         btn_zero = 1'($urandom % 2);
         btn_one  = 1'($urandom % 2);
         cyc($urandom_range(1, 12));
      end
      btn_zero = 0; btn_one = 0;
      cyc(20);

      chk("scoreboard drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
